// File: rtl/linked_list_fifo_drain_pkg.sv
// Shared helpers for the linked-list FIFO and its drain: index widths and count-field slicing.
`define LLF_CNT_FIELD(vec, g, w) vec[((g)+1)*(w)-1 -: (w)]

package linked_list_fifo_drain_pkg;

  localparam int LLF_WIDTH = 64;
  localparam int LLF_DEPTH = 2048;
  localparam int LLF_FIFOS = 4;

  // Bits needed to hold 'value'; never less than 1 so single-queue builds still get a port.
  function automatic int llf_log2(input int value);
    int n;
    int v;
    n = 0;
    v = value;
    while (v > 0) begin
      n++;
      v = v >> 1;
    end
    return (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/linked_list_fifo_drain_skid_buf2.sv
// Two-entry valid/ready buffer for {fifo id, data}; registered output, no write-to-read bypass.
// Writes are unconditional strobes, so the producer must hold its own credit; a write while full is dropped.
module llf_skid_buf2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_i,
  input  logic [W-1:0] wr_dat_i,
  output logic         rd_vld_o,
  input  logic         rd_rdy_i,
  output logic [W-1:0] rd_dat_o,
  output logic [1:0]   cnt_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         rd;
  logic         wr_ok;

  always_comb begin
    rd       = (cnt_q != 2'd0) && rd_rdy_i;
    wr_ok    = wr_i && (cnt_q != 2'd2);
    cnt_d    = cnt_q;
    if (wr_ok && !rd) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!wr_ok && rd) begin
      cnt_d = cnt_q - 2'd1;
    end
    wr_ptr_d = wr_ok ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = rd ? ~rd_ptr_q : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_dat_i;
    end
  end

  assign rd_vld_o = (cnt_q != 2'd0);
  assign rd_dat_o = mem_q[rd_ptr_q];
  assign cnt_o    = cnt_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && wr_i && (cnt_q == 2'd2)) begin
      $display("llf_skid_buf2: write while full, word dropped at %0t", $time);
    end
  end
`endif

endmodule

// File: rtl/linked_list_fifo_drain.sv
// Round-robin drain of the linked-list multi-FIFO into one tagged valid/ready stream; pop to out_valid is 2 cycles.
// Pops are credit-limited to the 2-entry skid buffer; LINKED_LIST_FIFO_DRAIN_STRICT_PRIO_EN selects lowest-index priority.
module linked_list_fifo_drain
  import linked_list_fifo_drain_pkg::*;
#(
  parameter int WIDTH      = LLF_WIDTH,
  parameter int DEPTH      = LLF_DEPTH,
  parameter int FIFOS      = LLF_FIFOS,
  parameter int LOG2_FIFOS = llf_log2(FIFOS - 1),
  parameter int LOG2_DEPTH = llf_log2(DEPTH - 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LOG2_DEPTH*FIFOS-1:0] count_i,
  input  logic [WIDTH-1:0]            q_i,
  input  logic [FIFOS-1:0]            pop_enable_i,
  output logic                        pop_o,
  output logic [LOG2_FIFOS-1:0]       pop_fifo_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [WIDTH-1:0]            out_data_o,
  output logic [LOG2_FIFOS-1:0]       out_fifo_o,
  output logic                        busy_o
);

  logic [FIFOS-1:0]      eligible;
  logic                  any_eligible;
  logic [LOG2_FIFOS-1:0] sel;
  logic                  pop;
  logic [1:0]            occ;
  logic [1:0]            buf_cnt;
  logic                  inflight_q, inflight_d;
  logic [LOG2_FIFOS-1:0] inflight_fifo_q, inflight_fifo_d;

  always_comb begin
    for (int g = 0; g < FIFOS; g++) begin
      eligible[g] = (`LLF_CNT_FIELD(count_i, g, LOG2_DEPTH) != '0) && pop_enable_i[g];
    end
    any_eligible = |eligible;
  end

`ifdef LINKED_LIST_FIFO_DRAIN_STRICT_PRIO_EN
  always_comb begin
    sel = '0;
    for (int g = FIFOS - 1; g >= 0; g--) begin
      if (eligible[g]) sel = LOG2_FIFOS'(g);
    end
  end
`else
  logic [LOG2_FIFOS-1:0] rr_q, rr_d;

  // Scan backwards from rr+FIFOS-1 so the candidate closest to rr is written last and wins.
  always_comb begin
    int idx;
    sel = '0;
    for (int k = FIFOS - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= FIFOS) idx = idx - FIFOS;
      if (eligible[idx]) sel = LOG2_FIFOS'(idx);
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (pop) begin
      rr_d = (sel == LOG2_FIFOS'(FIFOS - 1)) ? '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= '0;
    else     rr_q <= rr_d;
  end
`endif

  // Words owed to the skid buffer never exceed its two slots, counting the one in flight.
  always_comb begin
    occ             = buf_cnt + {1'b0, inflight_q};
    pop             = !rst && any_eligible &&
                      ((occ < 2'd2) || ((occ == 2'd2) && out_valid_o && out_ready_i));
    inflight_d      = pop;
    inflight_fifo_d = pop ? sel : inflight_fifo_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q      <= 1'b0;
      inflight_fifo_q <= '0;
    end else begin
      inflight_q      <= inflight_d;
      inflight_fifo_q <= inflight_fifo_d;
    end
  end

  llf_skid_buf2 #(
    .W(LOG2_FIFOS + WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .wr_i     (inflight_q),
    .wr_dat_i ({inflight_fifo_q, q_i}),
    .rd_vld_o (out_valid_o),
    .rd_rdy_i (out_ready_i),
    .rd_dat_o ({out_fifo_o, out_data_o}),
    .cnt_o    (buf_cnt)
  );

  assign pop_o      = pop;
  assign pop_fifo_o = pop ? sel : '0;
  assign busy_o     = inflight_q || (buf_cnt != 2'd0);

endmodule

// File: tb/tb_linked_list_fifo_drain.sv
// Drain bench: a queue-based FIFO model feeds the DUT; a negedge monitor predicts pops and outputs.
module tb_linked_list_fifo_drain;

  localparam int W  = 64;
  localparam int NF = 4;
  localparam int LF = 2;
  localparam int LD = 11;

  logic           clk = 1'b0;
  logic           rst;
  logic [LD*NF-1:0] count_i;
  logic [W-1:0]   q_i;
  logic [NF-1:0]  pop_enable_i;
  logic           out_ready_i;
  logic           pop_o;
  logic [LF-1:0]  pop_fifo_o;
  logic           out_valid_o;
  logic [W-1:0]   out_data_o;
  logic [LF-1:0]  out_fifo_o;
  logic           busy_o;

  always #5 clk = ~clk;

  linked_list_fifo_drain #(
    .WIDTH(W), .DEPTH(2048), .FIFOS(NF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .count_i      (count_i),
    .q_i          (q_i),
    .pop_enable_i (pop_enable_i),
    .pop_o        (pop_o),
    .pop_fifo_o   (pop_fifo_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .out_fifo_o   (out_fifo_o),
    .busy_o       (busy_o)
  );

  typedef struct {
    logic [W-1:0] d;
    int           f;
    int           c;
  } sb_t;

  sb_t          sb[$];
  logic [W-1:0] fq[NF][$];
  int           add_tot[NF];
  int           added[NF];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           rr_m = 0;
  int           seq = 0;
  logic [W-1:0] q_next = '0;
  logic [LD*NF-1:0] cnt_next = '0;
  logic         final_req = 1'b0;
  logic         final_done = 1'b0;

  int           sel_m, gi;
  logic         any_m, ev, ep;
  sb_t          e;
  logic [W-1:0] w;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor and reference model; sole owner of the FIFO contents and scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (final_req && !final_done) begin
      chk("drain_scoreboard_empty", W'(sb.size()), '0);
      for (int g = 0; g < NF; g++) chk("drain_fifo_empty", W'(fq[g].size()), '0);
      chk("drain_busy", W'(busy_o), '0);
      final_done = 1'b1;
    end
    q_next = {$urandom, $urandom};
    if (rst) begin
      chk("pop_during_reset", W'(pop_o), '0);
      sb.delete();
      rr_m = 0;
    end else begin
      any_m = 1'b0;
      sel_m = 0;
      for (int k = NF - 1; k >= 0; k--) begin
        gi = (rr_m + k) % NF;
        if ((count_i[gi*LD +: LD] != '0) && pop_enable_i[gi]) begin
          any_m = 1'b1;
          sel_m = gi;
        end
      end
      ev = (sb.size() > 0) && (sb[0].c <= cyc - 2);
      ep = any_m && ((sb.size() < 2) || ((sb.size() == 2) && ev && out_ready_i));
      chk("out_valid", W'(out_valid_o), W'(ev));
      chk("busy", W'(busy_o), W'(sb.size() != 0));
      chk("pop", W'(pop_o), W'(ep));
      chk("pop_fifo", W'(pop_fifo_o), ep ? W'(sel_m) : '0);
      if (ev && out_valid_o && out_ready_i) begin
        e = sb.pop_front();
        chk("out_data", out_data_o, e.d);
        chk("out_fifo", W'(out_fifo_o), W'(e.f));
      end
      if (pop_o) begin
        gi = int'(pop_fifo_o);
        chk("pop_nonempty_queue", W'(fq[gi].size() != 0), W'(1));
        if (fq[gi].size() != 0) begin
          w = fq[gi].pop_front();
          sb.push_back('{w, gi, cyc});
          q_next = w;
        end
`ifndef LINKED_LIST_FIFO_DRAIN_STRICT_PRIO_EN
        rr_m = (gi + 1) % NF;
`endif
      end
    end
    for (int g = 0; g < NF; g++) begin
      while (added[g] < add_tot[g]) begin
        seq++;
        fq[g].push_back({$urandom, 32'(seq)});
        added[g]++;
      end
      cnt_next[g*LD +: LD] = LD'(fq[g].size());
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      q_i     = q_next;
      count_i = cnt_next;
    end
  endtask

  task automatic add(input int g, input int n);
    add_tot[g] = add_tot[g] + n;
  endtask

  initial begin
    for (int g = 0; g < NF; g++) begin
      add_tot[g] = 0;
      added[g]   = 0;
    end
    rst          = 1'b1;
    out_ready_i  = 1'b0;
    pop_enable_i = '1;
    count_i      = '0;
    q_i          = '0;
    step(3);
    rst = 1'b0;
    step(10);

    out_ready_i = 1'b1;
    add(1, 3);
    step(12);

    for (int g = 0; g < NF; g++) add(g, 2);
    step(16);

    out_ready_i = 1'b0;
    add(0, 8);
    step(10);
    out_ready_i = 1'b1;
    step(14);

    pop_enable_i = 4'b1011;
    add(0, 1);
    add(2, 5);
    add(3, 2);
    step(8);
    pop_enable_i = '1;
    step(14);

    // Reset lands while one word is in flight and one is buffered.
    out_ready_i = 1'b0;
    add(0, 4);
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    out_ready_i = 1'b1;
    step(12);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 15) begin
        gi = int'($urandom_range(NF - 1));
        if (count_i[gi*LD +: LD] < 11'd30) add(gi, int'($urandom_range(4, 1)));
      end
      out_ready_i = ($urandom_range(99) < 70);
      if ($urandom_range(99) < 5) pop_enable_i = NF'($urandom);
      rst = ($urandom_range(999) == 0);
      step(1);
    end

    rst          = 1'b0;
    out_ready_i  = 1'b1;
    pop_enable_i = '1;
    for (int i = 0; i < 400; i++) begin
      if ((count_i == '0) && !busy_o) break;
      step(1);
    end
    step(2);
    final_req = 1'b1;
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
